// File: rtl/tcdm_bank_arbiter.sv
// rtl/tcdm_bank_arbiter.sv - NumIn-to-1 TCDM bank arbiter with aging and response routing
// Round-robin or external-priority arbitration; a starving requester preempts the normal order.
module tcdm_bank_arbiter #(
  parameter int unsigned NumIn         = 4,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter bit          WriteRespOn   = 1'b1,
  parameter bit          ExtPrio       = 1'b0,
  parameter int unsigned MaxWait       = 15,
  localparam int unsigned PtrW         = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumIn-1:0]                       req_i,
  input  logic [NumIn-1:0]                       wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]     wdata_i,
  output logic [NumIn-1:0]                       gnt_o,
  output logic [NumIn-1:0]                       vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]    rdata_o,
  input  logic [PtrW-1:0]                        rr_i,
  output logic                                   req_o,
  output logic [ReqDataWidth-1:0]                wdata_o,
  input  logic                                   gnt_i,
  input  logic [RespDataWidth-1:0]               rdata_i
);

  localparam int unsigned    AgeW    = $clog2(MaxWait + 1);
  localparam logic [AgeW-1:0] AgeMax  = AgeW'(MaxWait);
  localparam logic [PtrW:0]   NumInW  = (PtrW + 1)'(NumIn);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NumIn - 1);

  logic [PtrW-1:0]  ptr_q;
  logic [PtrW-1:0]  ptr;
  logic [PtrW-1:0]  winner;
  logic [PtrW-1:0]  win_req;
  logic [PtrW-1:0]  win_starve;
  logic [PtrW:0]    scan;
  logic             any_starve;
  logic             found_req;
  logic             handshake;
  logic [NumIn-1:0] starving;
  logic [AgeW-1:0]  age_q [NumIn];
  logic [RespLat-1:0] pipe_v;
  logic [PtrW-1:0]    pipe_idx [RespLat];

  // An out-of-range external pointer (non power-of-two NumIn) falls back to index 0.
  always_comb begin
    ptr = ptr_q;
    if (ExtPrio) begin
      ptr = (rr_i > LastIdx) ? '0 : rr_i;
    end
  end

  always_comb begin
    starving = '0;
    for (int i = 0; i < NumIn; i++) begin
      starving[i] = req_i[i] && (age_q[i] == AgeMax);
    end
  end

  // Cyclic scan starting at ptr; starving requesters take precedence over plain ones.
  always_comb begin
    any_starve = 1'b0;
    found_req  = 1'b0;
    win_starve = '0;
    win_req    = '0;
    scan       = '0;
    for (int k = 0; k < NumIn; k++) begin
      scan = {1'b0, ptr} + (PtrW + 1)'(k);
      if (scan >= NumInW) begin
        scan = scan - NumInW;
      end
      if (!any_starve && starving[scan[PtrW-1:0]]) begin
        any_starve = 1'b1;
        win_starve = scan[PtrW-1:0];
      end
      if (!found_req && req_i[scan[PtrW-1:0]]) begin
        found_req = 1'b1;
        win_req   = scan[PtrW-1:0];
      end
    end
    winner = any_starve ? win_starve : win_req;
  end

  assign req_o     = |req_i;
  assign handshake = req_o && gnt_i;
  assign wdata_o   = wdata_i[winner];

  always_comb begin
    gnt_o         = '0;
    gnt_o[winner] = handshake;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (!ExtPrio && handshake) begin
      ptr_q <= (winner == LastIdx) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIn; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        if (req_i[i] && !gnt_o[i]) begin
          if (age_q[i] != AgeMax) begin
            age_q[i] <= age_q[i] + 1'b1;
          end
        end else begin
          age_q[i] <= '0;
        end
      end
    end
  end

  // Fixed-latency bank: the winner index rides alongside the request until data returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_v <= '0;
      for (int s = 0; s < RespLat; s++) begin
        pipe_idx[s] <= '0;
      end
    end else begin
      pipe_v[0]   <= handshake && (!wen_i[winner] || WriteRespOn);
      pipe_idx[0] <= winner;
      for (int s = 1; s < RespLat; s++) begin
        pipe_v[s]   <= pipe_v[s-1];
        pipe_idx[s] <= pipe_idx[s-1];
      end
    end
  end

  always_comb begin
    vld_o                        = '0;
    vld_o[pipe_idx[RespLat-1]]   = pipe_v[RespLat-1];
  end

  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      rdata_o[i] = rdata_i;
    end
  end

endmodule
